// File: rtl/dram_sched_pkg.sv
// dram_sched_pkg
// Shared types and default timing for the DRAM command scheduler:
//   cmd_e    - command encoding driven on the dram_if cmd bus
//   state_e  - scheduler FSM states
//   DEF_*    - default widths and timing (in clk cycles)
//   tmr_load - converts a command spacing into a down-counter load value
package dram_sched_pkg;

    typedef enum logic [1:0] {
        CMD_ACT   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_PRE   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_ACT     = 3'd2,
        ST_RW      = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_e;

    localparam int DEF_ROW_W      = 6;
    localparam int DEF_COL_W      = 5;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_T_RCD      = 2;
    localparam int DEF_T_RP       = 2;
    localparam int DEF_T_RAS      = 4;
    localparam int DEF_RD_TIMEOUT = 15;

    localparam int TMR_W = 8;

    // A timer loaded at the end of cycle n reads zero in cycle n+cycles, so
    // the load value is one less than the spacing being enforced.
    function automatic logic [TMR_W-1:0] tmr_load(input int cycles);
        return (cycles > 0) ? TMR_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/dram_timer.sv
// dram_timer
// Loadable saturating down-counter. expired is high whenever the count is 0.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (count cleared = expired)
//   load     in   load load_val this cycle (takes priority over counting)
//   load_val in   W  value to load
//   expired  out  count is zero
module dram_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched
// Request-side scheduler for the dram_if command bus. Accepts one read/write
// request at a time, tracks the single open row, inserts PRE/ACT as needed and
// enforces tRP/tRCD/tRAS. Read data is returned as a one-cycle response pulse,
// or as an error response if the DRAM does not answer within RD_TIMEOUT cycles.
//
// Build option: DRAM_SCHED_CLOSE_PAGE_EN selects a close-page policy (PRE after
// every access, each request starts with ACT). Undefined: open-page policy.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we/req_row/req_col/req_wdata  request fields, latched on accept
//   rsp_valid/rsp_data/rsp_err     one-cycle read response
//   cmd_vld/cmd/row/col/wr_data    dram_if command bus (fields hold when idle)
//   rd_data/dram_valid             read data return from DRAM
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a request, decides hit / miss / cold
// ST_PRE     | waiting for tRAS, then issues PRE
// ST_ACT     | waiting for tRP, then issues ACT with the latched row
// ST_RW      | waiting for tRCD, then issues READ or WRITE
// ST_RD_WAIT | waiting for dram_valid or read timeout
module dram_cmd_sched
    import dram_sched_pkg::*;
#(
    parameter int ROW_W      = DEF_ROW_W,
    parameter int COL_W      = DEF_COL_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int T_RCD      = DEF_T_RCD,
    parameter int T_RP       = DEF_T_RP,
    parameter int T_RAS      = DEF_T_RAS,
    parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              cmd_vld,
    output logic [1:0]        cmd,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              dram_valid
);

    state_e state_q, state_d;

    logic              lat_we;
    logic [ROW_W-1:0]  lat_row;
    logic [COL_W-1:0]  lat_col;
    logic [DATA_W-1:0] lat_wdata;

    logic              open_vld_q;
    logic [ROW_W-1:0]  open_row_q;

    cmd_e              last_cmd_q;
    logic [ROW_W-1:0]  last_row_q;
    logic [COL_W-1:0]  last_col_q;
    logic [DATA_W-1:0] last_wdata_q;

    logic accept, issue, capture, timeout;
    cmd_e issue_cmd;
    logic ld_rcd, ld_rp, ld_ras, ld_to;
    logic rcd_exp, rp_exp, ras_exp, to_exp;

    dram_timer #(.W(TMR_W)) u_trcd (
        .clk(clk), .rst(rst), .load(ld_rcd), .load_val(tmr_load(T_RCD)), .expired(rcd_exp)
    );
    dram_timer #(.W(TMR_W)) u_trp (
        .clk(clk), .rst(rst), .load(ld_rp), .load_val(tmr_load(T_RP)), .expired(rp_exp)
    );
    dram_timer #(.W(TMR_W)) u_tras (
        .clk(clk), .rst(rst), .load(ld_ras), .load_val(tmr_load(T_RAS)), .expired(ras_exp)
    );
    dram_timer #(.W(TMR_W)) u_trd_to (
        .clk(clk), .rst(rst), .load(ld_to), .load_val(tmr_load(RD_TIMEOUT)), .expired(to_exp)
    );

    // rst gates ready so no handshake is seen while reset is held.
    assign req_ready = (state_q == ST_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        issue     = 1'b0;
        issue_cmd = CMD_PRE;
        capture   = 1'b0;
        timeout   = 1'b0;
        ld_rcd    = 1'b0;
        ld_rp     = 1'b0;
        ld_ras    = 1'b0;
        ld_to     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
`ifdef DRAM_SCHED_CLOSE_PAGE_EN
                    state_d = ST_ACT;
`else
                    if (open_vld_q && (open_row_q == req_row)) begin
                        state_d = ST_RW;
                    end else if (open_vld_q) begin
                        state_d = ST_PRE;
                    end else begin
                        state_d = ST_ACT;
                    end
`endif
                end
            end
            ST_PRE: begin
                if (ras_exp) begin
                    issue     = 1'b1;
                    issue_cmd = CMD_PRE;
                    ld_rp     = 1'b1;
`ifdef DRAM_SCHED_CLOSE_PAGE_EN
                    // Close-page PRE only ever follows a completed access.
                    state_d = ST_IDLE;
`else
                    state_d = ST_ACT;
`endif
                end
            end
            ST_ACT: begin
                if (rp_exp) begin
                    issue     = 1'b1;
                    issue_cmd = CMD_ACT;
                    ld_rcd    = 1'b1;
                    ld_ras    = 1'b1;
                    state_d   = ST_RW;
                end
            end
            ST_RW: begin
                if (rcd_exp) begin
                    issue = 1'b1;
                    if (lat_we) begin
                        issue_cmd = CMD_WRITE;
`ifdef DRAM_SCHED_CLOSE_PAGE_EN
                        state_d = ST_PRE;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        issue_cmd = CMD_READ;
                        ld_to     = 1'b1;
                        state_d   = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // A valid strobe in the last timeout cycle still wins.
                if (dram_valid) begin
                    capture = 1'b1;
                end else if (to_exp) begin
                    timeout = 1'b1;
                end
                if (dram_valid || to_exp) begin
`ifdef DRAM_SCHED_CLOSE_PAGE_EN
                    state_d = ST_PRE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we       <= 1'b0;
            lat_row      <= '0;
            lat_col      <= '0;
            lat_wdata    <= '0;
            open_vld_q   <= 1'b0;
            open_row_q   <= '0;
            last_cmd_q   <= CMD_PRE;
            last_row_q   <= '0;
            last_col_q   <= '0;
            last_wdata_q <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid <= capture || timeout;
            rsp_err   <= timeout;
            if (capture) begin
                rsp_data <= rd_data;
            end else if (timeout) begin
                rsp_data <= '0;
            end
            if (accept) begin
                lat_we    <= req_we;
                lat_row   <= req_row;
                lat_col   <= req_col;
                lat_wdata <= req_wdata;
            end
            if (issue) begin
                last_cmd_q <= issue_cmd;
                case (issue_cmd)
                    CMD_ACT: begin
                        last_row_q <= lat_row;
                        open_vld_q <= 1'b1;
                        open_row_q <= lat_row;
                    end
                    CMD_PRE: begin
                        open_vld_q <= 1'b0;
                    end
                    CMD_READ: begin
                        last_col_q <= lat_col;
                    end
                    CMD_WRITE: begin
                        last_col_q   <= lat_col;
                        last_wdata_q <= lat_wdata;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Command fields show the latched request while a command is issued and
    // otherwise hold the value of the last command that used them.
    assign cmd_vld = issue;
    assign cmd     = issue ? issue_cmd : last_cmd_q;
    assign row     = (issue && issue_cmd == CMD_ACT) ? lat_row : last_row_q;
    assign col     = (issue && (issue_cmd == CMD_READ || issue_cmd == CMD_WRITE))
                     ? lat_col : last_col_q;
    assign wr_data = (issue && issue_cmd == CMD_WRITE) ? lat_wdata : last_wdata_q;

endmodule
